// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of writeback, mul/div handshake, decode hazard and register-file write signals
// shared by the write-port scheduler and whoever drives it.
interface regfile_wb_scheduler_if;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic        md_valid;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        md_ready;

   logic        md_issue;
   logic [4:0]  md_issue_rd;
   logic        md_issue_ready;

   logic [4:0]  dec_src_a;
   logic [4:0]  dec_src_b;
   logic [4:0]  dec_rd;
   logic        dec_stall;

   logic        stall_pipe;

   logic        rf_load;
   logic [4:0]  rf_dest;
   logic [31:0] rf_in;

   modport master (
      output wb_valid, wb_rd, wb_data,
      output md_valid, md_rd, md_data,
      input  md_ready,
      output md_issue, md_issue_rd,
      input  md_issue_ready,
      output dec_src_a, dec_src_b, dec_rd,
      input  dec_stall,
      input  stall_pipe,
      input  rf_load, rf_dest, rf_in
   );

   modport slave (
      input  wb_valid, wb_rd, wb_data,
      input  md_valid, md_rd, md_data,
      output md_ready,
      input  md_issue, md_issue_rd,
      output md_issue_ready,
      input  dec_src_a, dec_src_b, dec_rd,
      output dec_stall,
      output stall_pipe,
      output rf_load, rf_dest, rf_in
   );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between pipeline writeback and the mul/div unit,
// tracks mul/div destinations still owed, and forces a drain when mul/div is starved.
module regfile_wb_scheduler #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   regfile_wb_scheduler_if.slave  sched
);

   typedef enum logic {
      NORMAL = 1'b0,
      DRAIN  = 1'b1
   } state_t;

   localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

   state_t      state_reg;
   state_t      state_next;
   logic [3:0]  starve_cnt_reg;
   logic [3:0]  starve_cnt_next;
   logic [31:0] pending_reg;
   logic [31:0] pending_next;

   logic        md_ready;
   logic        md_fire;
   logic        md_blocked;
   logic        issue_take;
   logic        src_valid;
   logic [4:0]  rf_dest;
   logic [31:0] rf_in;
   logic        stall_pipe;

   logic [31:0] clear_vec;
   logic [31:0] set_vec;
   logic [31:0] live_vec;

   // The pipeline has no ready, so it always owns the port when valid.
   assign md_ready   = !sched.wb_valid;
   assign md_fire    = sched.md_valid && md_ready;
   assign md_blocked = sched.md_valid && !md_ready;

   always_comb begin
      src_valid = 1'b0;
      rf_dest   = 5'd0;
      rf_in     = 32'd0;
      if (sched.wb_valid) begin
         src_valid = 1'b1;
         rf_dest   = sched.wb_rd;
         rf_in     = sched.wb_data;
      end else if (sched.md_valid) begin
         src_valid = 1'b1;
         rf_dest   = sched.md_rd;
         rf_in     = sched.md_data;
      end
   end

   assign sched.md_ready = md_ready;
   assign sched.rf_load  = src_valid && (rf_dest != 5'd0);
   assign sched.rf_dest  = rf_dest;
   assign sched.rf_in    = rf_in;

   // No same-cycle clear bypass on issue: a register being drained this cycle is still busy.
   assign sched.md_issue_ready = !pending_reg[sched.md_issue_rd];
   assign issue_take = sched.md_issue && !pending_reg[sched.md_issue_rd]
                       && (sched.md_issue_rd != 5'd0);

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_score
         assign clear_vec[gi] = md_fire && (sched.md_rd == 5'(gi));
         assign set_vec[gi]   = issue_take && (sched.md_issue_rd == 5'(gi));
         // A register being written this cycle is forwarded by the register file.
         assign live_vec[gi]  = pending_reg[gi] && !clear_vec[gi];
      end
   endgenerate

   always_comb begin
      pending_next    = (pending_reg & ~clear_vec) | set_vec;
      pending_next[0] = 1'b0;
   end

   assign sched.dec_stall = live_vec[sched.dec_src_a]
                          | live_vec[sched.dec_src_b]
                          | live_vec[sched.dec_rd];

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_reg <= 32'd0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   // Starvation FSM: state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= NORMAL;
         starve_cnt_reg <= 4'd0;
      end else begin
         state_reg      <= state_next;
         starve_cnt_reg <= starve_cnt_next;
      end
   end

   // Starvation FSM: next state.
   always_comb begin
      state_next      = state_reg;
      starve_cnt_next = 4'd0;
      case (state_reg)
         NORMAL: begin
            if (md_blocked) begin
               if (starve_cnt_reg == STARVE_LAST) begin
                  state_next = DRAIN;
               end else begin
                  starve_cnt_next = starve_cnt_reg + 4'd1;
               end
            end
         end
         DRAIN: begin
            if (md_fire || !sched.md_valid) begin
               state_next = NORMAL;
            end
         end
         default: state_next = NORMAL;
      endcase
   end

   // Starvation FSM: outputs.
   always_comb begin
      stall_pipe = (state_reg == DRAIN);
   end

   assign sched.stall_pipe = stall_pipe;

   // The pipeline must be frozen while draining.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(state_reg == DRAIN && sched.wb_valid));
      end
   end

endmodule
